// File: rtl/decoder2x4_pulse.sv
// decoder2x4_pulse: sequential 2-to-4 decoder with a timed one-hot strobe.
// Accepts a 2-bit index over valid/ready, drives the matching one-hot line for
// HOLD_CYCLES cycles, then holds an all-zero gap of GAP_CYCLES cycles before
// accepting the next index. done pulses on the first cycle after each hold.
module decoder2x4_pulse #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] code,
    output logic       in_ready,
    output logic [3:0] Y,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MaxCnt = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    // Counter reload values; GapLoad is unused when there is no gap phase.
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad  = (GAP_CYCLES > 0) ? CntW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      code_q, code_d;
    logic [3:0]      y_q, y_d;
    logic            done_q, done_d;

    // Next-state logic: handshake acceptance, hold/gap countdown, done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    code_d  = code;
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end
            end

            StHold: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Y is computed from the next state so the registered output is glitch-free
    // and lines up exactly with the HOLD cycles.
    always_comb begin
        y_d = 4'b0000;
        if (state_d == StHold) begin
            y_d = 4'b0001 << code_d;
        end
    end

    // State registers with synchronous active-high reset; reset beats acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= 2'b00;
            y_q     <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    // Ready and busy are pure decodes of the current state.
    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q == StHold) || (state_q == StGap);
    end

    assign Y    = y_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder2x4_pulse.sv
// Testbench for decoder2x4_pulse: three parameter sets run in parallel.
// The reference model tracks only "cycles since the last acceptance"; a
// scoreboard of expected one-hot runs is checked by a run monitor.
module tb_decoder2x4_pulse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        int len;
    } exp_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int H = (g == 0) ? 4 : 1;
        localparam int G = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        logic       rst = 1'b1;
        logic       in_valid = 1'b0;
        logic [1:0] code = 2'd0;
        logic       in_ready, busy, done;
        logic [3:0] y;
        logic       fin = 1'b0;

        decoder2x4_pulse #(
            .HOLD_CYCLES(H),
            .GAP_CYCLES (G)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .in_valid(in_valid),
            .code    (code),
            .in_ready(in_ready),
            .Y       (y),
            .busy    (busy),
            .done    (done)
        );

        // Model state: cycles since acceptance (-1 = nothing in flight).
        int       since = -1;
        int       cyc = 0;
        bit       chk_en = 1'b0;
        bit       acc_flag = 1'b0;
        int       timeouts = 0;
        exp_t     sb[$];
        exp_t     e_new;
        exp_t     e_tr;
        int       run_len = 0;
        logic [3:0] run_val = 4'b0000;
        bit       exp_ready, exp_busy, exp_done;

        task automatic close_run();
            exp_t e;
            if (sb.size() == 0) begin
                chk($sformatf("cfg%0d unexpected Y run cyc%0d", g, cyc), int'(run_val), 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("cfg%0d Y value cyc%0d", g, cyc), int'(run_val), 1 << e.code);
                chk($sformatf("cfg%0d Y length cyc%0d", g, cyc), run_len, e.len);
            end
            run_len = 0;
        endtask

        // Monitor + model, evaluated mid-cycle on the falling edge.
        initial begin
            forever begin
                @(negedge clk);
                cyc++;
                acc_flag = 1'b0;
                if (chk_en) begin
                    exp_ready = (since < 0) || (since >= H + G + 1);
                    exp_busy  = (since >= 1) && (since <= H + G);
                    exp_done  = (since == H + 1);
                    chk($sformatf("cfg%0d in_ready cyc%0d", g, cyc), int'(in_ready),
                        int'(exp_ready));
                    chk($sformatf("cfg%0d busy cyc%0d", g, cyc), int'(busy), int'(exp_busy));
                    chk($sformatf("cfg%0d done cyc%0d", g, cyc), int'(done), int'(exp_done));

                    if (run_len > 0 && y !== run_val) close_run();
                    if (y != 4'b0000) begin
                        if (run_len == 0) run_val = y;
                        run_len++;
                    end

                    // Advance the model using the inputs seen at the coming edge.
                    if (rst) begin
                        if (since >= 1 && since <= H && sb.size() > 0) begin
                            e_tr = sb.pop_back();
                            e_tr.len = since;
                            sb.push_back(e_tr);
                        end
                        since = -1;
                    end else if (in_valid && exp_ready) begin
                        e_new.code = int'(code);
                        e_new.len  = H;
                        sb.push_back(e_new);
                        since = 1;
                        acc_flag = 1'b1;
                    end else if (since >= 0) begin
                        since++;
                    end
                end
            end
        end

        task automatic drive(input logic r, input logic v, input logic [1:0] c);
            rst = r;
            in_valid = v;
            code = c;
            @(posedge clk);
            #1;
        endtask

        // Hold in_valid/code until the model reports acceptance.
        task automatic send(input logic [1:0] c);
            int t;
            rst = 1'b0;
            in_valid = 1'b1;
            code = c;
            for (t = 0; t < 64; t++) begin
                @(negedge clk);
                #1;
                if (acc_flag) break;
                @(posedge clk);
                #1;
            end
            if (t >= 64) timeouts++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        initial begin
            logic [1:0] c;
            // Reset two cycles with a valid code pending; it must not be taken.
            rst = 1'b1;
            in_valid = 1'b1;
            code = 2'd3;
            @(posedge clk);
            #1;
            chk_en = 1'b1;
            drive(1'b1, 1'b1, 2'd3);
            repeat (3) drive(1'b0, 1'b0, 2'd0);

            if (g == 0) begin
                for (int i = 0; i < 4; i++) begin
                    send(2'(i));
                    repeat (6) drive(1'b0, 1'b0, 2'd0);
                end
                // Input changes during HOLD/GAP are ignored.
                send(2'd2);
                for (int i = 0; i < 5; i++) drive(1'b0, (i % 2) == 1, 2'd1);
                repeat (3) drive(1'b0, 1'b0, 2'd0);
                // Reset on the second HOLD cycle.
                send(2'd1);
                drive(1'b0, 1'b0, 2'd0);
                drive(1'b1, 1'b0, 2'd0);
                repeat (2) drive(1'b0, 1'b0, 2'd0);
                send(2'd3);
                repeat (8) drive(1'b0, 1'b0, 2'd0);
            end else if (g == 1) begin
                // Back-to-back with valid held high and codes alternating 0/3.
                c = 2'd0;
                rst = 1'b0;
                in_valid = 1'b1;
                code = c;
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    #1;
                    if (acc_flag) c = (c == 2'd0) ? 2'd3 : 2'd0;
                    @(posedge clk);
                    #1;
                    code = c;
                end
                repeat (4) drive(1'b0, 1'b0, 2'd0);
            end else begin
                send(2'd0);
                repeat (8) drive(1'b0, 1'b0, 2'd0);
            end

            // Randomized phase with occasional resets.
            for (int i = 0; i < 300; i++) begin
                drive($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)));
            end
            repeat (H + G + 4) drive(1'b0, 1'b0, 2'd0);

            chk($sformatf("cfg%0d scoreboard drained", g), sb.size(), 0);
            chk($sformatf("cfg%0d send timeouts", g), timeouts, 0);
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        for (t = 0; t < 20000; t++) begin
            @(posedge clk);
            if (cfg[0].fin && cfg[1].fin && cfg[2].fin) break;
        end
        chk("all configs finished", int'(t < 20000), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder2x4_pulse.md
# decoder2x4_pulse

Sequential 2-to-4 decoder: the decode-side counterpart of `priority_encoder4x2`. It accepts a 2-bit index over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. After that it holds a programmable idle gap before it accepts the next index. It sits downstream of the priority encoder and turns the encoded winner back into a timed one-hot select/grant strobe.

## Interface
- `HOLD_CYCLES`, default 4: cycles the one-hot output stays asserted per accepted code; legal range ≥1.
- `GAP_CYCLES`, default 1: cycles of all-zero output after each hold before `in_ready` returns; legal range ≥0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: source presents a valid `code`.
- `code` input 2: index to decode (0..3).
- `in_ready` output 1: block can accept a code this cycle.
- `Y` output 4: one-hot decoded output, registered; `Y = 4'b0001 << code_latched` during HOLD, else 0.
- `busy` output 1: high in HOLD or GAP.
- `done` output 1: single-cycle pulse on the first cycle after a hold ends.

## Operation
- States: IDLE, HOLD, GAP. Down-counter width is `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`.
- IDLE: `in_ready`=1, `Y`=0, `busy`=0.
  - On an edge with `in_valid`=1, latch `code`, load counter = `HOLD_CYCLES-1`, and go to HOLD.
- HOLD: `Y` = one-hot of the latched code, `busy`=1, `in_ready`=0. Counter decrements each edge.
  - At counter 0, go to GAP with counter = `GAP_CYCLES-1` if `GAP_CYCLES`>0; otherwise go to IDLE.
- GAP: `Y`=0, `busy`=1, `in_ready`=0. At counter 0, go to IDLE.
- `done` is registered. It is 1 for exactly one cycle: the first cycle after HOLD exits, whether that cycle is in GAP or IDLE.
- `code` and `in_valid` are ignored outside IDLE. The source must hold `in_valid`/`code` until `in_ready`. A code changing mid-HOLD has no effect.
- `Y` is never multi-hot and never glitches. It is a direct register output.
- `in_ready` is a combinational decode of state only. It has no combinational path from `in_valid` or `code`.

## Timing
- Reset: on an edge with `rst`=1, state goes to IDLE, counter=0, `Y`=0, `busy`=0, `done`=0, and the latched code is 0. Reset overrides any acceptance or count on the same edge.
- Reset mid-HOLD or mid-GAP: `Y`=0 and `in_ready`=1 from the next cycle. No `done` pulse is issued.
- Latency: code accepted on edge N means `Y` is valid from cycle N+1 through N+HOLD_CYCLES (exactly HOLD_CYCLES cycles).
  - `done`=1 in cycle N+HOLD_CYCLES+1.
  - `in_ready` returns in cycle N+HOLD_CYCLES+GAP_CYCLES+1.
- Back-to-back with GAP_CYCLES=0: a code can be accepted in the `done` cycle. This gives exactly one all-zero cycle between consecutive holds.
- Minimum acceptance interval is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- `rst` asserted together with `in_valid` in IDLE: reset wins and the code is not accepted.

## Test plan
- Reset and idle (HOLD=4, GAP=1): assert `rst` 2 cycles with `in_valid`=1 and `code`=3.
  - Required: `Y`=0000, `busy`=0, `done`=0, `in_ready`=1 after release; no code accepted during reset.
- Single decode per index: sequence `code`=0,1,2,3, each held with `in_valid` until accepted.
  - Required: `Y`=0001, 0010, 0100, 1000 respectively, each for exactly 4 cycles.
  - Required: `done` pulses 1 cycle after each hold; `in_ready` returns 6 cycles after each acceptance.
- Input changes ignored: accept `code`=2, then drive `code`=1 and toggle `in_valid` during HOLD and GAP.
  - Required: `Y` stays 0100 for 4 cycles, then 0000; only one acceptance occurs.
- Back-to-back, GAP=0, HOLD=1: hold `in_valid`=1 with alternating `code`=0/3.
  - Required: `Y` pattern 0001,0000,1000,0000,... with `done` high on every zero cycle.
- Reset mid-operation: accept `code`=1, assert `rst` on the 2nd HOLD cycle.
  - Required: `Y`=0000 and `in_ready`=1 on the next cycle, no `done` pulse.
  - Required: a new `code`=3 accepted after release yields a full 4-cycle `Y`=1000.
- Parameter corner HOLD=1, GAP=3: accept `code`=0.
  - Required: `Y`=0001 for 1 cycle, `done` on the next cycle, `busy` high for 4 cycles total, `in_ready` returning 5 cycles after acceptance.
